// File: rtl/wb_regfile_write_ctrl.sv
// wb_regfile_write_ctrl: shares the register-file write port between WB and debug, sequences halt/drain/step, counts commits
module wb_regfile_write_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int DRAIN_CYCLES = 4,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_wb_regwrite,
    input  logic [ADDR_WIDTH-1:0]  i_wb_rd,
    input  logic [DATA_WIDTH-1:0]  i_wb_data,
    input  logic                   i_dbg_halt_req,
    input  logic                   i_dbg_step,
    input  logic                   i_dbg_valid,
    input  logic [ADDR_WIDTH-1:0]  i_dbg_rd,
    input  logic [DATA_WIDTH-1:0]  i_dbg_data,
    output logic                   o_dbg_ready,
    output logic                   o_stall,
    output logic                   o_halted,
    output logic                   o_rf_we,
    output logic [ADDR_WIDTH-1:0]  o_rf_addr,
    output logic [DATA_WIDTH-1:0]  o_rf_data,
    output logic [COUNT_WIDTH-1:0] o_commit_count
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP} state_t;
    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   dbg_xfer;
    logic [ADDR_WIDTH-1:0]  sel_rd;
    logic [DATA_WIDTH-1:0]  sel_data;
    // next-state logic: dropping halt_req always returns to RUN, even over a step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                state_d = i_dbg_halt_req ? DRAIN : RUN;
                cnt_d   = i_dbg_halt_req ? 4'(DRAIN_CYCLES) : 4'd0;
            end
            DRAIN: begin
                state_d = !i_dbg_halt_req ? RUN : (cnt_q == 4'd1 ? HALTED : DRAIN);
                cnt_d   = !i_dbg_halt_req ? 4'd0 : cnt_q - 4'd1;
            end
            HALTED: state_d = !i_dbg_halt_req ? RUN : (i_dbg_step ? STEP : HALTED);
            default: begin
                state_d = i_dbg_halt_req ? DRAIN : RUN;
                cnt_d   = i_dbg_halt_req ? 4'(DRAIN_CYCLES) : 4'd0;
            end
        endcase
    end
    // write-port arbitration: WB never waits, debug only lands on a halted core
    always_comb begin
        o_dbg_ready = (state_q == HALTED) & ~i_wb_regwrite;
        dbg_xfer    = i_dbg_valid & o_dbg_ready;
        sel_rd      = i_wb_regwrite ? i_wb_rd : i_dbg_rd;
        sel_data    = i_wb_regwrite ? i_wb_data : i_dbg_data;
        we_d        = (i_wb_regwrite | dbg_xfer) & (sel_rd != '0);
    end
    // state, registered write port and commit counter
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            if (we_d) begin
                addr_q <= sel_rd;
                data_q <= sel_data;
            end
            if (i_wb_regwrite && i_wb_rd != '0) count_q <= count_q + 1'b1;
        end
    end
    assign o_stall        = (state_q == DRAIN) | (state_q == HALTED);
    assign o_halted       = state_q == HALTED;
    assign o_rf_we        = we_q;
    assign o_rf_addr      = addr_q;
    assign o_rf_data      = data_q;
    assign o_commit_count = count_q;
endmodule
